// File: rtl/wam_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wam_pkg : shared sizes, LFSR constants and helpers for the mole generator.
// Revision 1.0
// ---------------------------------------------------------------------------
package wam_pkg;

  localparam int N_HOLES = 8;
  localparam int HOLE_W  = 3;
  localparam int LFSR_W  = 16;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wam_lfsr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wam_lfsr : free-running 16-bit Galois LFSR, reloads its seed on reset.
// Revision 1.0
// ---------------------------------------------------------------------------
module wam_lfsr
  import wam_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic              clk_19,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge clk_19) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/wam_mole.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wam_mole : spawns moles at pseudo-random holes, expires/clears them, counts hits and misses.
// Revision 1.0
// ---------------------------------------------------------------------------
module wam_mole
  import wam_pkg::*;
#(
  parameter int unsigned       LIFE_TICKS = 96,
  parameter int unsigned       SPAWN_GAP  = 32,
  parameter int unsigned       MAX_MOLES  = 3,
  parameter logic [LFSR_W-1:0] LFSR_SEED  = LFSR_SEED_DEFAULT
) (
  input  logic               clk_19,
  input  logic               rst,
  input  logic               en,
  input  logic [N_HOLES-1:0] hit,
  output logic [N_HOLES-1:0] holes,
  output logic               spawn,
  output logic [7:0]         score,
  output logic [7:0]         miss
);

  localparam logic [7:0] LIFE_INIT = 8'(LIFE_TICKS - 1);
  localparam logic [7:0] GAP_INIT  = 8'(SPAWN_GAP - 1);
  localparam logic [3:0] MAX_CNT   = 4'(MAX_MOLES);

  logic [LFSR_W-1:0]  lfsr;
  logic [HOLE_W-1:0]  idx;
  logic               unused_lfsr_hi;

  logic [N_HOLES-1:0] holes_q, holes_d;
  logic [N_HOLES-1:0] hit_ev, exp_ev;
  logic [7:0]         life_q [N_HOLES];
  logic [7:0]         life_d [N_HOLES];
  logic [7:0]         spawn_cnt_q, spawn_cnt_d;
  logic [7:0]         score_q, score_d;
  logic [7:0]         miss_q, miss_d;
  logic [8:0]         score_sum, miss_sum;
  logic               spawn_q, spawn_ok;

  wam_lfsr #(
    .LFSR_SEED(LFSR_SEED)
  ) u_lfsr (
    .clk_19(clk_19),
    .rst   (rst),
    .q     (lfsr)
  );

  assign idx            = lfsr[HOLE_W-1:0];
  assign unused_lfsr_hi = ^lfsr[LFSR_W-1:HOLE_W];

  // Attempt uses the registered occupancy, before this cycle's hits/expiries land.
  assign spawn_ok = en && (spawn_cnt_q == 8'd0) && !holes_q[idx]
                    && (popcount8(holes_q) < MAX_CNT);

  for (genvar i = 0; i < N_HOLES; i++) begin : g_hole
    logic place;
    logic keep;
    assign place      = spawn_ok && (idx == HOLE_W'(i));
    assign hit_ev[i]  = en && holes_q[i] && hit[i];
    assign exp_ev[i]  = en && holes_q[i] && !hit[i] && (life_q[i] == 8'd0);
    assign keep       = en && holes_q[i] && !hit[i] && (life_q[i] != 8'd0);
    assign holes_d[i] = place || keep;
    assign life_d[i]  = place ? LIFE_INIT : (keep ? life_q[i] - 8'd1 : 8'd0);
  end

  assign spawn_cnt_d = (!en || (spawn_cnt_q == 8'd0)) ? GAP_INIT : spawn_cnt_q - 8'd1;

  assign score_sum = {1'b0, score_q} + {5'd0, popcount8(hit_ev)};
  assign miss_sum  = {1'b0, miss_q} + {5'd0, popcount8(exp_ev)};
  assign score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
  assign miss_d    = miss_sum[8] ? 8'hFF : miss_sum[7:0];

  always_ff @(posedge clk_19) begin
    if (rst) begin
      holes_q     <= '0;
      spawn_q     <= 1'b0;
      spawn_cnt_q <= GAP_INIT;
      score_q     <= 8'd0;
      miss_q      <= 8'd0;
      for (int i = 0; i < N_HOLES; i++) begin
        life_q[i] <= 8'd0;
      end
    end else begin
      holes_q     <= holes_d;
      spawn_q     <= spawn_ok;
      spawn_cnt_q <= spawn_cnt_d;
      score_q     <= score_d;
      miss_q      <= miss_d;
      for (int i = 0; i < N_HOLES; i++) begin
        life_q[i] <= life_d[i];
      end
    end
  end

  assign holes = holes_q;
  assign spawn = spawn_q;
  assign score = score_q;
  assign miss  = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_wam_mole.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wam_mole : three differently-parameterised mole generators against a lifetime/cadence model.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_wam_mole;

  localparam int              L_P    [3] = '{96, 4, 20};
  localparam int              G_P    [3] = '{32, 50, 2};
  localparam int              M_P    [3] = '{3, 3, 1};
  localparam logic [15:0]     SEED_P [3] = '{16'hACE1, 16'hACE1, 16'h1234};

  logic       clk_19 = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] m_hit [3];

  logic [7:0] hit_a, hit_b, hit_c;
  logic [7:0] holes_a, holes_b, holes_c;
  logic       spawn_a, spawn_b, spawn_c;
  logic [7:0] score_a, score_b, score_c;
  logic [7:0] miss_a, miss_b, miss_c;

  assign hit_a = m_hit[0];
  assign hit_b = m_hit[1];
  assign hit_c = m_hit[2];

  always #5 clk_19 = ~clk_19;

  wam_mole #(.LIFE_TICKS(96), .SPAWN_GAP(32), .MAX_MOLES(3), .LFSR_SEED(16'hACE1)) u_dut_a (
    .clk_19(clk_19), .rst(rst), .en(en), .hit(hit_a),
    .holes(holes_a), .spawn(spawn_a), .score(score_a), .miss(miss_a));

  wam_mole #(.LIFE_TICKS(4), .SPAWN_GAP(50), .MAX_MOLES(3), .LFSR_SEED(16'hACE1)) u_dut_b (
    .clk_19(clk_19), .rst(rst), .en(en), .hit(hit_b),
    .holes(holes_b), .spawn(spawn_b), .score(score_b), .miss(miss_b));

  wam_mole #(.LIFE_TICKS(20), .SPAWN_GAP(2), .MAX_MOLES(1), .LFSR_SEED(16'h1234)) u_dut_c (
    .clk_19(clk_19), .rst(rst), .en(en), .hit(hit_c),
    .holes(holes_c), .spawn(spawn_c), .score(score_c), .miss(miss_c));

  // Reference state: moles remembered by the edge they were born on.
  logic [15:0] m_lfsr  [3];
  int          m_run   [3];
  logic [7:0]  m_holes [3];
  int          m_born  [3][8];
  int          m_score [3];
  int          m_miss  [3];
  logic        m_spawn [3];
  int          m_t;

  logic [24:0] sb_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [7:0] rand_hit(input logic [7:0] occ, input int den, input bit spur);
    logic [7:0] h;
    h = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (occ[i] && ($urandom_range(den - 1, 0) == 0)) h[i] = 1'b1;
    end
    if (spur && ($urandom_range(31, 0) == 0)) h[$urandom_range(7, 0)] = 1'b1;
    return h;
  endfunction

  task automatic model_step(input int k);
    logic [7:0] nh;
    int         nhit;
    int         nexp;
    int         idx;
    if (rst) begin
      m_lfsr[k]  = SEED_P[k];
      m_run[k]   = 0;
      m_holes[k] = 8'h00;
      m_score[k] = 0;
      m_miss[k]  = 0;
      m_spawn[k] = 1'b0;
      return;
    end
    idx        = int'(m_lfsr[k] % 16'd8);
    m_lfsr[k]  = lfsr_next(m_lfsr[k]);
    m_spawn[k] = 1'b0;
    if (!en) begin
      m_run[k]   = 0;
      m_holes[k] = 8'h00;
      return;
    end
    nh   = m_holes[k];
    nhit = 0;
    nexp = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_holes[k][i]) begin
        if (m_hit[k][i]) begin
          nh[i] = 1'b0;
          nhit++;
        end else if (m_t - m_born[k][i] == L_P[k]) begin
          nh[i] = 1'b0;
          nexp++;
        end
      end
    end
    m_run[k]++;
    if ((m_run[k] % G_P[k] == 0) && !m_holes[k][idx] && ($countones(m_holes[k]) < M_P[k])) begin
      nh[idx]        = 1'b1;
      m_born[k][idx] = m_t;
      m_spawn[k]     = 1'b1;
    end
    m_holes[k] = nh;
    m_score[k] = (m_score[k] + nhit > 255) ? 255 : m_score[k] + nhit;
    m_miss[k]  = (m_miss[k] + nexp > 255) ? 255 : m_miss[k] + nexp;
  endtask

  task automatic tick();
    for (int k = 0; k < 3; k++) begin
      model_step(k);
      sb_q.push_back({m_holes[k], m_spawn[k], 8'(m_score[k]), 8'(m_miss[k])});
    end
    m_t++;
    @(posedge clk_19);
    @(negedge clk_19);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Monitor: every edge each DUT presents a new output tuple; compare against the queue.
  initial begin : p_monitor
    logic [24:0] act [3];
    logic [24:0] ev;
    forever begin
      @(posedge clk_19);
      #1;
      act[0] = {holes_a, spawn_a, score_a, miss_a};
      act[1] = {holes_b, spawn_b, score_b, miss_b};
      act[2] = {holes_c, spawn_c, score_c, miss_c};
      if (sb_q.size() >= 3) begin
        for (int k = 0; k < 3; k++) begin
          ev = sb_q.pop_front();
          n_checks++;
          if (act[k] === ev) n_pass++;
          else $display("FAIL dut%0d t=%0d: got holes=%h spawn=%b score=%0d miss=%0d, expected holes=%h spawn=%b score=%0d miss=%0d",
                        k, m_t, act[k][24:17], act[k][16], act[k][15:8], act[k][7:0],
                        ev[24:17], ev[16], ev[15:8], ev[7:0]);
        end
      end
    end
  end

  task automatic run_random(input int cycles, input bit c_hits);
    for (int c = 0; c < cycles; c++) begin
      m_hit[0] = rand_hit(m_holes[0], 16, 1'b1);
      m_hit[1] = rand_hit(m_holes[1], 8, 1'b1);
      m_hit[2] = c_hits ? rand_hit(m_holes[2], 2, 1'b1) : 8'h00;
      tick();
    end
  endtask

  initial begin : p_driver
    m_t = 0;
    for (int k = 0; k < 3; k++) m_hit[k] = 8'h00;
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Quiet start: first spawns, lifetimes and expiries with no hits at all.
    en = 1'b1;
    repeat (100) tick();

    // Hit every hole of the slow generator at once while several moles are up.
    m_hit[0] = 8'hFF;
    tick();
    m_hit[0] = 8'h00;

    // Long random play; the fast generator first saturates score, then miss.
    run_random(2000, 1'b1);
    run_random(7000, 1'b0);
    chk("c_score_saturated", int'(score_c), 255);
    chk("c_miss_saturated", int'(miss_c), 255);
    run_random(20, 1'b1);
    chk("c_score_holds", int'(score_c), 255);

    // Game pause with moles up, then resume.
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    run_random(300, 1'b1);

    // Mid-game reset with enable and hits still asserted.
    m_hit[0] = 8'hFF;
    m_hit[1] = 8'hFF;
    m_hit[2] = 8'hFF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_holes_a", int'(holes_a), 0);
    chk("rst_score_c", int'(score_c), 0);
    run_random(300, 1'b1);

    for (int k = 0; k < 3; k++) m_hit[k] = 8'h00;
    tick();
    @(posedge clk_19);
    #2;
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
